branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Sits beside the pc and fetch stages. Fetch looks up the current PC combinationally and gets a predicted next PC.
- The execute stage reports resolved branches through an update port one cycle-edge later.
- Replaces the fixed pc+4 / resolve-late scheme and its flush-on-every-taken-branch penalty. Includes saturating performance counters.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2..1024.
- CNT_W, 2, direction counter width; 1..4.
- PERF_W, 32, width of each performance counter.
- Derived: IDX_W = log2(ENTRIES); TAG_W = 30 - IDX_W.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- lookup_pc  in  32  PC presented by fetch this cycle
- lookup_hit  out  1  valid entry with matching tag
- predict_taken  out  1  prediction is taken
- predict_pc  out  32  predicted next PC
- update_en  in  1  resolved branch/jump this cycle; qualified by stage enable
- update_pc  in  32  PC of the resolved instruction
- update_taken  in  1  actual outcome
- update_target  in  32  actual taken target
- update_mispredict  in  1  prediction used for this instruction was wrong; counts only
- clear_en  in  1  synchronous invalidate-all
- perf_updates  out  PERF_W  resolved-branch count
- perf_mispredicts  out  PERF_W  mispredict count

Behaviour:
- Reset (async, nRST low): all valid bits 0, all counters 0, tags and targets 0, perf counters 0. Consequently lookup_hit=0, predict_taken=0, predict_pc=lookup_pc+4 immediately.
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Lookup (combinational, zero latency):
  - lookup_hit = valid[idx] && tag matches.
  - predict_taken = lookup_hit && counter MSB == 1.
  - predict_pc = target[idx] if predict_taken, else lookup_pc+4; 32-bit wrap on 0xFFFFFFFC+4 gives 0.
- Update (registered at rising edge when update_en=1):
  - Hit, taken: counter increments, saturating at 2^CNT_W-1; target overwritten with update_target.
  - Hit, not-taken: counter decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate/replace. valid=1, tag, target written; counter = weakly taken (MSB set, other bits 0, i.e. 2 for CNT_W=2, 1 for CNT_W=1).
  - Miss, not-taken: no state change.
- Perf counters: when update_en=1, perf_updates increments; perf_mispredicts also increments if update_mispredict=1. Both saturate at all-ones and never wrap.
- Same-cycle read/write: a lookup and an update to the same index in one cycle → the lookup sees pre-update state; no bypass. The new state is visible the next cycle.
- clear_en=1: all valid bits and counters cleared at the edge; perf counters unaffected.
  - If clear_en and update_en are both 1: clear wins, entry state is not written. Perf counters still count the update.
- Reset mid-operation: asynchronous clear as above; an in-flight update is discarded.
- update_* inputs are ignored when update_en=0, including X values.

Decomposition:
- cpu_types_pkg additions:
  - btb_entry_t struct {valid, tag[TAG_W], target[32]}.
  - function sat_inc/sat_dec on CNT_W-bit counters.
  - localparam WORD_ADDR_LSB = 2.
- One natural sub-module: sat_counter (parametrised width, inc/dec/load/clear, async reset). Instantiated per entry via generate, and reused for the two perf counters with load unused.
- Storage: flop array, not SRAM, so lookup stays combinational.

Test Plan (ENTRIES=16, CNT_W=2):
1. Reset, lookup_pc=0x40 → lookup_hit=0, predict_taken=0, predict_pc=0x44; perf counters 0.
2. Update pc=0x40, taken, target=0x100. Next cycle lookup 0x40 → hit=1, taken=1, predict_pc=0x100. Then one not-taken update → counter=1, predict_pc=0x44.
3. Conflict: entry 0x40 valid, then taken update pc=0x80 (same idx 0, tag 2) target=0x200 → lookup 0x40 misses (pc+4=0x44); lookup 0x80 gives 0x200.
4. Saturation: 5 taken updates on 0x40 → counter stays 3; then 2 not-taken → counter 1, predict not-taken. 4 further not-taken → counter 0, no underflow.
5. Same cycle: lookup 0x40 (entry absent) with update 0x40 taken → that cycle hit=0, predict_pc=0x44; next cycle hit=1, predict_pc=target.
6. clear_en together with update_en (pc=0x40, taken, mispredict=1) → entry stays invalid; perf_updates +1, perf_mispredicts +1. With PERF_W=4, after 16 updates perf_updates stays 15.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared constants and saturating-arithmetic helpers for the branch predictor slice.
package branch_predictor_pkg;

  localparam int WORD_ADDR_LSB = 2;
  localparam int SAT_MAX_W     = 64;

  typedef logic [SAT_MAX_W-1:0] sat_word_t;

  function automatic sat_word_t sat_max(input int w);
    return (w >= SAT_MAX_W) ? '1 : ((sat_word_t'(1) << w) - sat_word_t'(1));
  endfunction

  // Counters narrower than SAT_MAX_W are zero-extended into a sat_word_t before calling these.
  function automatic sat_word_t sat_inc(input sat_word_t v, input int w);
    return (v >= sat_max(w)) ? sat_max(w) : v + sat_word_t'(1);
  endfunction

  function automatic sat_word_t sat_dec(input sat_word_t v);
    return (v == '0) ? '0 : v - sat_word_t'(1);
  endfunction

endpackage

// File: rtl/branch_predictor_counter.sv
// Generic saturating up/down counter with synchronous clear/load and async active-low reset.
module sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  logic [W-1:0] count_next;
  sat_word_t    inc_w;
  sat_word_t    dec_w;

  // Clear beats load beats counting; simultaneous inc and dec cancel out.
  always_comb begin
    inc_w      = sat_inc(sat_word_t'(count), W);
    dec_w      = sat_dec(sat_word_t'(count));
    count_next = count;
    if (clear)
      count_next = '0;
    else if (load)
      count_next = load_val;
    else if (inc && !dec)
      count_next = inc_w[W-1:0];
    else if (dec && !inc)
      count_next = dec_w[W-1:0];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and perf counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       lookup_pc,
  output logic              lookup_hit,
  output logic              predict_taken,
  output logic [31:0]       predict_pc,
  input  logic              update_en,
  input  logic [31:0]       update_pc,
  input  logic              update_taken,
  input  logic [31:0]       update_target,
  input  logic              update_mispredict,
  input  logic              clear_en,
  output logic [PERF_W-1:0] perf_updates,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } btb_entry_t;

  btb_entry_t                    entries [ENTRIES];
  logic [ENTRIES-1:0][CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  btb_entry_t       lk_entry;
  btb_entry_t       up_entry;
  logic             up_hit;
  logic             up_write;
  logic             unused_pc_lsbs;

  assign lk_idx = lookup_pc[IDX_W+WORD_ADDR_LSB-1:WORD_ADDR_LSB];
  assign lk_tag = lookup_pc[31:IDX_W+WORD_ADDR_LSB];
  assign up_idx = update_pc[IDX_W+WORD_ADDR_LSB-1:WORD_ADDR_LSB];
  assign up_tag = update_pc[31:IDX_W+WORD_ADDR_LSB];

  assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  // Lookup reads the registered state only, so a same-cycle update is not bypassed.
  assign lk_entry      = entries[lk_idx];
  assign lookup_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign predict_taken = lookup_hit && cnt_q[lk_idx][CNT_W-1];
  assign predict_pc    = predict_taken ? lk_entry.target : lookup_pc + 32'd4;

  assign up_entry = entries[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);
  assign up_write = update_en && !clear_en;

  // A taken outcome always (re)writes the entry: a hit refreshes the target, a miss replaces it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++)
        entries[i] <= '0;
    end else if (clear_en) begin
      for (int i = 0; i < ENTRIES; i++)
        entries[i].valid <= 1'b0;
    end else if (update_en && update_taken) begin
      entries[up_idx] <= '{valid: 1'b1, tag: up_tag, target: update_target};
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_dir
    logic sel;
    assign sel = up_write && (up_idx == IDX_W'(i));

    sat_counter #(.W(CNT_W)) u_dir (
      .CLK      (CLK),
      .nRST     (nRST),
      .clear    (clear_en),
      .load     (sel && !up_hit && update_taken),
      .load_val (CNT_WEAK),
      .inc      (sel && up_hit && update_taken),
      .dec      (sel && up_hit && !update_taken),
      .count    (cnt_q[i])
    );
  end

  // Perf counters keep counting through clear_en; only reset zeroes them.
  sat_counter #(.W(PERF_W)) u_perf_updates (
    .CLK      (CLK),
    .nRST     (nRST),
    .clear    (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .inc      (update_en),
    .dec      (1'b0),
    .count    (perf_updates)
  );

  sat_counter #(.W(PERF_W)) u_perf_mispredicts (
    .CLK      (CLK),
    .nRST     (nRST),
    .clear    (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .inc      (update_en && update_mispredict),
    .dec      (1'b0),
    .count    (perf_mispredicts)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected lookup/perf values, a negedge monitor checks them.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        lookup_hit;
  logic        predict_taken;
  logic [31:0] predict_pc;
  logic        update_en = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;
  logic        update_mispredict = 1'b0;
  logic        clear_en = 1'b0;
  logic [3:0]  perf_updates;
  logic [3:0]  perf_mispredicts;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] pc;
    logic        chk_perf;
    logic [3:0]  pu;
    logic [3:0]  pm;
  } exp_t;

  exp_t exp_q[$];

  branch_predictor #(.ENTRIES(16), .CNT_W(2), .PERF_W(4)) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .lookup_pc         (lookup_pc),
    .lookup_hit        (lookup_hit),
    .predict_taken     (predict_taken),
    .predict_pc        (predict_pc),
    .update_en         (update_en),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .clear_en          (clear_en),
    .perf_updates      (perf_updates),
    .perf_mispredicts  (perf_mispredicts)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs just after the edge and records what the lookup should show this cycle.
  task automatic applyStimulus(input string name, input logic [31:0] lpc,
                               input logic uen, input logic [31:0] upc, input logic ut,
                               input logic [31:0] utgt, input logic umis, input logic clr,
                               input logic eh, input logic et, input logic [31:0] epc,
                               input logic cp, input logic [3:0] pu, input logic [3:0] pm);
    exp_t e;
    @(posedge CLK);
    #1;
    lookup_pc         = lpc;
    update_en         = uen;
    update_pc         = upc;
    update_taken      = ut;
    update_target     = utgt;
    update_mispredict = umis;
    clear_en          = clr;
    e.name = name; e.hit = eh; e.taken = et; e.pc = epc;
    e.chk_perf = cp; e.pu = pu; e.pm = pm;
    exp_q.push_back(e);
  endtask

  // Asserts reset mid-cycle while an update is in flight, checking outputs while reset is held.
  task automatic doReset();
    exp_t e;
    @(posedge CLK);
    #1;
    lookup_pc = 32'h40; update_en = 1'b1; update_pc = 32'h40;
    update_taken = 1'b1; update_target = 32'h600; update_mispredict = 1'b1; clear_en = 1'b0;
    #1;
    nRST = 1'b0;
    e.name = "async_reset"; e.hit = 1'b0; e.taken = 1'b0; e.pc = 32'h44;
    e.chk_perf = 1'b1; e.pu = 4'd0; e.pm = 4'd0;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    update_en = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput({e.name, ".hit"},   32'(lookup_hit),    32'(e.hit));
      checkOutput({e.name, ".taken"}, 32'(predict_taken), 32'(e.taken));
      checkOutput({e.name, ".pc"},    predict_pc,         e.pc);
      if (e.chk_perf) begin
        checkOutput({e.name, ".perf_upd"}, 32'(perf_updates),     32'(e.pu));
        checkOutput({e.name, ".perf_mis"}, 32'(perf_mispredicts), 32'(e.pm));
      end
    end
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;

    applyStimulus("reset_lookup",     32'h40, 0, 32'h00, 0, 32'h000, 0, 0, 0, 0, 32'h44,  1, 0, 0);
    applyStimulus("same_cycle_alloc", 32'h40, 1, 32'h40, 1, 32'h100, 1, 0, 0, 0, 32'h44,  1, 0, 0);
    applyStimulus("after_alloc",      32'h40, 1, 32'h40, 0, 32'h000, 1, 0, 1, 1, 32'h100, 1, 1, 1);
    applyStimulus("after_dec",        32'h40, 0, 32'h00, 0, 32'h000, 0, 0, 1, 0, 32'h44,  1, 2, 2);
    applyStimulus("conflict_write",   32'h40, 1, 32'h80, 1, 32'h200, 0, 0, 1, 0, 32'h44,  1, 2, 2);
    applyStimulus("conflict_old",     32'h40, 0, 32'h00, 0, 32'h000, 0, 0, 0, 0, 32'h44,  1, 3, 2);
    applyStimulus("conflict_new",     32'h80, 0, 32'h00, 0, 32'h000, 0, 0, 1, 1, 32'h200, 0, 0, 0);

    applyStimulus("sat_inc0",         32'h40, 1, 32'h40, 1, 32'h300, 0, 0, 0, 0, 32'h44,  1, 3, 2);
    for (int k = 0; k < 4; k++)
      applyStimulus("sat_inc",        32'h40, 1, 32'h40, 1, 32'h300, 0, 0, 1, 1, 32'h300, 0, 0, 0);
    applyStimulus("sat_dec0",         32'h40, 1, 32'h40, 0, 32'h000, 0, 0, 1, 1, 32'h300, 0, 0, 0);
    applyStimulus("sat_dec1",         32'h40, 1, 32'h40, 0, 32'h000, 0, 0, 1, 1, 32'h300, 0, 0, 0);
    applyStimulus("sat_weak_nt",      32'h40, 0, 32'h00, 0, 32'h000, 0, 0, 1, 0, 32'h44,  0, 0, 0);
    for (int k = 0; k < 4; k++)
      applyStimulus("underflow",      32'h40, 1, 32'h40, 0, 32'h000, 0, 0, 1, 0, 32'h44,  0, 0, 0);
    applyStimulus("floor",            32'h40, 0, 32'h00, 0, 32'h000, 0, 0, 1, 0, 32'h44,  0, 0, 0);
    applyStimulus("floor_inc",        32'h40, 1, 32'h40, 1, 32'h300, 0, 0, 1, 0, 32'h44,  0, 0, 0);
    applyStimulus("floor_check",      32'h40, 0, 32'h00, 0, 32'h000, 0, 0, 1, 0, 32'h44,  1, 15, 2);
    applyStimulus("perf_sat",         32'h40, 1, 32'h40, 0, 32'h000, 1, 0, 1, 0, 32'h44,  1, 15, 2);
    applyStimulus("perf_sat_chk",     32'h40, 0, 32'h00, 0, 32'h000, 0, 0, 1, 0, 32'h44,  1, 15, 3);

    doReset();
    applyStimulus("post_reset",       32'h40, 0, 32'h00, 0, 32'h000, 0, 0, 0, 0, 32'h44,  1, 0, 0);
    applyStimulus("clr_alloc",        32'h40, 1, 32'h40, 1, 32'h100, 1, 0, 0, 0, 32'h44,  1, 0, 0);
    applyStimulus("clr_with_upd",     32'h40, 1, 32'h40, 1, 32'h700, 1, 1, 1, 1, 32'h100, 1, 1, 1);
    applyStimulus("after_clr",        32'h40, 0, 32'h00, 0, 32'h000, 0, 0, 0, 0, 32'h44,  1, 2, 2);
    applyStimulus("pc_wrap",    32'hFFFFFFFC, 0, 32'h00, 0, 32'h000, 0, 0, 0, 0, 32'h0,   0, 0, 0);
    applyStimulus("upd_en_low",       32'h40, 0, 32'h40, 1, 32'h900, 1, 0, 0, 0, 32'h44,  1, 2, 2);
    applyStimulus("upd_en_low_chk",   32'h40, 0, 32'h00, 0, 32'h000, 0, 0, 0, 0, 32'h44,  1, 2, 2);
    applyStimulus("idx7_alloc",       32'h1C, 1, 32'h1C, 1, 32'h1234, 0, 0, 0, 0, 32'h20, 0, 0, 0);
    applyStimulus("idx7_hit",         32'h1C, 0, 32'h00, 0, 32'h000, 0, 0, 1, 1, 32'h1234, 1, 3, 2);
    applyStimulus("lsb_ignored",      32'h1F, 0, 32'h00, 0, 32'h000, 0, 0, 1, 1, 32'h1234, 0, 0, 0);
    applyStimulus("idx7_tagmiss",     32'h5C, 0, 32'h00, 0, 32'h000, 0, 0, 0, 0, 32'h60,  0, 0, 0);

    repeat (3) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
